// File: rtl/dmem_ctrl_if.sv
// Word-wide req/ack data-memory bus between dmem_ctrl (master) and the memory (slave).
interface dmem_ctrl_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns the datapath's load/store strobes into one
// req/ack bus transaction, stalls the datapath meanwhile, flags misalignment and timeouts.
module dmem_ctrl #(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   DW       = 32,
    parameter int unsigned   TIMEOUT  = 16,
    parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memread,
    input  logic          memwrite,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          stall,
    output logic          misalign,
    output logic          bus_err,
    dmem_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    state_e      state_q;
    logic [15:0] cnt_q;
    logic        access;
    logic        aligned;

    always_comb begin
        access  = memread | memwrite;
        aligned = (addr[1:0] == 2'b00);
        // Stall starts in the request cycle itself so the PC never advances past the access.
        stall   = (state_q == StBusy) || ((state_q == StIdle) && access && aligned);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            rdata         <= '0;
            misalign      <= 1'b0;
            bus_err       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
        end else begin
            misalign <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (access) begin
                        if (aligned) begin
                            bus.bus_addr  <= {addr[AW-1:2], 2'b00};
                            bus.bus_wdata <= wdata;
                            bus.bus_we    <= memwrite;
                            bus.bus_req   <= 1'b1;
                            cnt_q         <= '0;
                            state_q       <= StBusy;
                        end else begin
                            // Rejected: loads return zero, stores are simply dropped.
                            misalign <= 1'b1;
                            if (!memwrite) begin
                                rdata <= '0;
                            end
                        end
                    end
                end
                StBusy: begin
                    if (bus.bus_ack) begin
                        if (!bus.bus_we) begin
                            rdata <= bus.bus_rdata;
                        end
                        bus.bus_req <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= StDone;
                    end else if (cnt_q == CntLast) begin
                        if (!bus.bus_we) begin
                            rdata <= ERR_DATA;
                        end
                        bus_err     <= 1'b1;
                        bus.bus_req <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StDone: begin
                    // Retiring instruction's strobes are still up here; ignore them.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized accesses
// compared against a transaction-level reference model.
module tb_dmem_ctrl;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    int vectors     = 0;
    int miscompares = 0;

    dmem_ctrl_if #(.AW(32), .DW(32)) bif ();

    dmem_ctrl #(
        .AW       (32),
        .DW       (32),
        .TIMEOUT  (TO),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memread  (memread),
        .memwrite (memwrite),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .misalign (misalign),
        .bus_err  (bus_err),
        .bus      (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shortest run of bus_req = 0 cycles between two requests.
    int zero_run    = 0;
    int mon_min_gap = 1000;
    bit mon_seen    = 0;
    always @(negedge clk) begin
        if (bif.bus_req === 1'b1) begin
            if (mon_seen && zero_run > 0 && zero_run < mon_min_gap) mon_min_gap = zero_run;
            mon_seen = 1;
            zero_run = 0;
        end else begin
            zero_run++;
        end
    end

    // Reference model: one whole access at a time.
    typedef struct {
        int          n_req;
        int          n_stall;
        int          n_mis;
        logic [31:0] rd;
        logic        err;
        logic [31:0] b_addr;
        logic [31:0] b_wdata;
        logic        b_we;
    } exp_t;

    logic [31:0] m_rdata = 32'h0;
    logic        m_err   = 1'b0;

    function automatic exp_t model(input logic rd, input logic wr, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rdat,
                                   input int waits);
        exp_t e;
        bit   acked;
        e.n_req   = 0;
        e.n_stall = 0;
        e.n_mis   = 0;
        e.b_addr  = 32'h0;
        e.b_wdata = 32'h0;
        e.b_we    = 1'b0;
        if (rd || wr) begin
            if (a[1:0] != 2'b00) begin
                e.n_mis = 1;
                if (!wr) m_rdata = 32'h0;
            end else begin
                acked     = (waits >= 0) && (waits < TO);
                e.n_req   = acked ? waits + 1 : TO;
                e.n_stall = e.n_req + 1;
                e.b_addr  = a & 32'hFFFF_FFFC;
                e.b_we    = wr;
                e.b_wdata = wd;
                if (!acked) m_err = 1'b1;
                if (!wr) m_rdata = acked ? rdat : 32'hDEAD_BEEF;
            end
        end
        e.rd  = m_rdata;
        e.err = m_err;
        return e;
    endfunction

    // Drives one instruction's access like the datapath would and plays the memory side.
    // Starts and ends 1 time unit after a rising edge. waits < 0 means never acknowledge.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdat,
                              input int waits, input int tail,
                              output int n_stall, output int n_req, output int n_mis,
                              output logic [31:0] rd_ret, output logic [31:0] rd_aft,
                              output logic [31:0] b_addr, output logic [31:0] b_wdata,
                              output logic b_we, output logic held, output logic err);
        int ret_cyc;
        int cyc;
        n_stall = 0; n_req = 0; n_mis = 0; held = 1'b1; ret_cyc = -1;
        rd_ret = 32'h0; rd_aft = 32'h0; b_addr = 32'h0; b_wdata = 32'h0; b_we = 1'b0;
        memread = rd; memwrite = wr; addr = a; wdata = wd;
        cyc = 0;
        while (cyc < 64) begin
            if (cyc > 0) begin
                addr  = $urandom;
                wdata = $urandom;
            end
            bif.bus_ack   = 1'b0;
            bif.bus_rdata = $urandom;
            if (bif.bus_req === 1'b1) begin
                if (n_req == 0) begin
                    b_addr  = bif.bus_addr;
                    b_we    = bif.bus_we;
                    b_wdata = bif.bus_wdata;
                end else if (bif.bus_addr !== b_addr || bif.bus_we !== b_we ||
                             bif.bus_wdata !== b_wdata) begin
                    held = 1'b0;
                end
                if (waits >= 0 && n_req == waits) begin
                    bif.bus_ack   = 1'b1;
                    bif.bus_rdata = rdat;
                end
                n_req++;
            end
            if (cyc > 0 && misalign === 1'b1) n_mis++;
            #1;
            if (ret_cyc < 0) begin
                if (stall === 1'b1) n_stall++;
                else begin
                    ret_cyc = cyc;
                    rd_ret  = rdata;
                end
            end
            if (ret_cyc >= 0 && cyc == ret_cyc + 1) rd_aft = rdata;
            @(posedge clk);
            #1;
            if (ret_cyc >= 0) begin
                if (cyc >= ret_cyc + tail) break;
                memread  = 1'b0;
                memwrite = 1'b0;
            end
            cyc++;
        end
        bif.bus_ack = 1'b0;
        err = bus_err;
    endtask

    task automatic test_reset;
        reset = 1'b0; memread = 1'b0; memwrite = 1'b0; addr = 32'h0; wdata = 32'h0;
        bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bif.bus_req !== 1'b0 || bif.bus_we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_req: req=%b we=%b, need 0 0", bif.bus_req, bif.bus_we);
        end
        vectors++;
        if (bif.bus_addr !== 32'h0 || bif.bus_wdata !== 32'h0 || rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, need all 0",
                     bif.bus_addr, bif.bus_wdata, rdata);
        end
        vectors++;
        if (stall !== 1'b0 || misalign !== 1'b0 || bus_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: stall=%b misalign=%b bus_err=%b, need 0 0 0",
                     stall, misalign, bus_err);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load;
        int n_stall, n_req, n_mis;
        logic [31:0] rd_ret, rd_aft, b_addr, b_wdata;
        logic b_we, held, err;
        exp_t e;
        e = model(1'b1, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 0);
        run_access(1'b1, 1'b0, 32'h40, 32'h5555_AAAA, 32'h1234_5678, 0, 2,
                   n_stall, n_req, n_mis, rd_ret, rd_aft, b_addr, b_wdata, b_we, held, err);
        vectors++;
        if (n_req !== 1 || b_addr !== 32'h40 || b_we !== 1'b0) begin
            miscompares++;
            $display("FAIL load_bus: req_cycles=%0d addr=%h we=%b, need 1 00000040 0",
                     n_req, b_addr, b_we);
        end
        vectors++;
        if (n_stall !== e.n_stall) begin
            miscompares++;
            $display("FAIL load_stall: stall_cycles=%0d, need %0d", n_stall, e.n_stall);
        end
        vectors++;
        if (rd_ret !== 32'h1234_5678 || rd_aft !== e.rd) begin
            miscompares++;
            $display("FAIL load_rdata: done=%h after=%h, need 12345678 %h", rd_ret, rd_aft, e.rd);
        end
        vectors++;
        if (n_mis !== 0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL load_flags: misalign_cycles=%0d bus_err=%b, need 0 0", n_mis, err);
        end
    endtask

    // Ack lands in the same BUSY cycle the timeout would fire: ack must win.
    task automatic test_store_waits;
        int n_stall, n_req, n_mis;
        logic [31:0] rd_ret, rd_aft, b_addr, b_wdata;
        logic b_we, held, err;
        exp_t e;
        e = model(1'b0, 1'b1, 32'h100, 32'hCAFE_F00D, 32'h0, 3);
        run_access(1'b0, 1'b1, 32'h100, 32'hCAFE_F00D, 32'h7777_7777, 3, 2,
                   n_stall, n_req, n_mis, rd_ret, rd_aft, b_addr, b_wdata, b_we, held, err);
        vectors++;
        if (n_req !== 4 || held !== 1'b1) begin
            miscompares++;
            $display("FAIL store_req: req_cycles=%0d held=%b, need 4 1", n_req, held);
        end
        vectors++;
        if (b_we !== 1'b1 || b_wdata !== 32'hCAFE_F00D || b_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL store_bus: we=%b wdata=%h addr=%h, need 1 cafef00d 00000100",
                     b_we, b_wdata, b_addr);
        end
        vectors++;
        if (n_stall !== 5) begin
            miscompares++;
            $display("FAIL store_stall: stall_cycles=%0d, need 5", n_stall);
        end
        vectors++;
        if (rd_aft !== e.rd || err !== e.err) begin
            miscompares++;
            $display("FAIL store_keep: rdata=%h bus_err=%b, need %h %b", rd_aft, err, e.rd, e.err);
        end
    endtask

    task automatic test_misalign;
        int n_stall, n_req, n_mis;
        logic [31:0] rd_ret, rd_aft, b_addr, b_wdata;
        logic b_we, held, err;
        exp_t e;
        e = model(1'b1, 1'b0, 32'h42, 32'h0, 32'h0, 0);
        run_access(1'b1, 1'b0, 32'h42, 32'h0, 32'hFFFF_0000, 0, 3,
                   n_stall, n_req, n_mis, rd_ret, rd_aft, b_addr, b_wdata, b_we, held, err);
        vectors++;
        if (n_req !== 0 || n_stall !== 0) begin
            miscompares++;
            $display("FAIL misalign_bus: req_cycles=%0d stall_cycles=%0d, need 0 0",
                     n_req, n_stall);
        end
        vectors++;
        if (n_mis !== 1) begin
            miscompares++;
            $display("FAIL misalign_pulse: misalign_cycles=%0d, need 1", n_mis);
        end
        vectors++;
        if (rd_aft !== e.rd) begin
            miscompares++;
            $display("FAIL misalign_rdata: rdata=%h, need %h", rd_aft, e.rd);
        end
    endtask

    task automatic test_timeout;
        int n_stall, n_req, n_mis;
        logic [31:0] rd_ret, rd_aft, b_addr, b_wdata, rdat;
        logic b_we, held, err;
        exp_t e;
        e = model(1'b1, 1'b0, 32'h200, 32'h0, 32'h0, -1);
        run_access(1'b1, 1'b0, 32'h200, 32'h0, 32'h0, -1, 2,
                   n_stall, n_req, n_mis, rd_ret, rd_aft, b_addr, b_wdata, b_we, held, err);
        vectors++;
        if (n_req !== TO || n_stall !== TO + 1) begin
            miscompares++;
            $display("FAIL timeout_len: req_cycles=%0d stall_cycles=%0d, need %0d %0d",
                     n_req, n_stall, TO, TO + 1);
        end
        vectors++;
        if (err !== 1'b1 || rd_ret !== 32'hDEAD_BEEF || rd_aft !== e.rd) begin
            miscompares++;
            $display("FAIL timeout_err: bus_err=%b rdata=%h, need 1 deadbeef", err, rd_ret);
        end
        rdat = $urandom;
        e = model(1'b1, 1'b0, 32'h204, 32'h0, rdat, 1);
        run_access(1'b1, 1'b0, 32'h204, 32'h0, rdat, 1, 2,
                   n_stall, n_req, n_mis, rd_ret, rd_aft, b_addr, b_wdata, b_we, held, err);
        vectors++;
        if (rd_ret !== rdat || err !== 1'b1 || n_stall !== e.n_stall) begin
            miscompares++;
            $display("FAIL timeout_after: rdata=%h bus_err=%b stall_cycles=%0d, need %h 1 %0d",
                     rd_ret, err, n_stall, rdat, e.n_stall);
        end
    endtask

    task automatic test_both_strobes;
        int n_stall, n_req, n_mis;
        logic [31:0] rd_ret, rd_aft, b_addr, b_wdata;
        logic b_we, held, err;
        exp_t e;
        e = model(1'b1, 1'b1, 32'h8, 32'h0BAD_F00D, 32'h1111_2222, 0);
        run_access(1'b1, 1'b1, 32'h8, 32'h0BAD_F00D, 32'h1111_2222, 0, 2,
                   n_stall, n_req, n_mis, rd_ret, rd_aft, b_addr, b_wdata, b_we, held, err);
        vectors++;
        if (b_we !== 1'b1 || b_addr !== 32'h8 || b_wdata !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL both_write: we=%b addr=%h wdata=%h, need 1 00000008 0badf00d",
                     b_we, b_addr, b_wdata);
        end
        vectors++;
        if (rd_aft !== e.rd) begin
            miscompares++;
            $display("FAIL both_rdata: rdata=%h, need %h", rd_aft, e.rd);
        end
    endtask

    task automatic test_back_to_back;
        int n_stall, n_req, n_mis;
        logic [31:0] rd_ret, rd_aft, b_addr, b_wdata, rdat;
        logic b_we, held, err;
        exp_t e;
        mon_min_gap = 1000;
        rdat = $urandom;
        e = model(1'b1, 1'b0, 32'h400, 32'h0, rdat, 0);
        run_access(1'b1, 1'b0, 32'h400, 32'h0, rdat, 0, 0,
                   n_stall, n_req, n_mis, rd_ret, rd_aft, b_addr, b_wdata, b_we, held, err);
        vectors++;
        if (rd_ret !== rdat || n_stall !== e.n_stall) begin
            miscompares++;
            $display("FAIL b2b_load: rdata=%h stall_cycles=%0d, need %h %0d",
                     rd_ret, n_stall, rdat, e.n_stall);
        end
        e = model(1'b0, 1'b1, 32'h404, 32'hA5A5_5A5A, 32'h0, 1);
        run_access(1'b0, 1'b1, 32'h404, 32'hA5A5_5A5A, 32'h0, 1, 2,
                   n_stall, n_req, n_mis, rd_ret, rd_aft, b_addr, b_wdata, b_we, held, err);
        vectors++;
        if (n_req !== e.n_req || b_we !== 1'b1 || b_addr !== 32'h404) begin
            miscompares++;
            $display("FAIL b2b_store: req_cycles=%0d we=%b addr=%h, need %0d 1 00000404",
                     n_req, b_we, b_addr, e.n_req);
        end
        vectors++;
        if (mon_min_gap !== 2) begin
            miscompares++;
            $display("FAIL b2b_gap: min req-low gap=%0d, need 2", mon_min_gap);
        end
    endtask

    task automatic test_random;
        int n_stall, n_req, n_mis, waits, sel;
        logic [31:0] rd_ret, rd_aft, b_addr, b_wdata, a, wd, rdat;
        logic b_we, held, err, rd, wr;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            sel   = $urandom_range(0, 3);
            rd    = sel[0];
            wr    = sel[1];
            a     = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            wd    = $urandom;
            rdat  = $urandom;
            waits = $urandom_range(0, 6) - 1;
            e = model(rd, wr, a, wd, rdat, waits);
            run_access(rd, wr, a, wd, rdat, waits, 1,
                       n_stall, n_req, n_mis, rd_ret, rd_aft, b_addr, b_wdata, b_we, held, err);
            vectors++;
            if (n_req !== e.n_req || n_stall !== e.n_stall || n_mis !== e.n_mis) begin
                miscompares++;
                $display("FAIL rand%0d_timing: req=%0d stall=%0d mis=%0d, need %0d %0d %0d",
                         i, n_req, n_stall, n_mis, e.n_req, e.n_stall, e.n_mis);
            end
            vectors++;
            if (rd_aft !== e.rd || err !== e.err) begin
                miscompares++;
                $display("FAIL rand%0d_result: rdata=%h bus_err=%b, need %h %b",
                         i, rd_aft, err, e.rd, e.err);
            end
            if (e.n_req > 0) begin
                vectors++;
                if (b_addr !== e.b_addr || b_we !== e.b_we || b_wdata !== e.b_wdata ||
                    held !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rand%0d_bus: addr=%h we=%b wdata=%h held=%b, need %h %b %h 1",
                             i, b_addr, b_we, b_wdata, held, e.b_addr, e.b_we, e.b_wdata);
                end
            end
        end
    endtask

    task automatic test_reset_midway;
        int n_stall, n_req, n_mis;
        logic [31:0] rd_ret, rd_aft, b_addr, b_wdata, rdat;
        logic b_we, held, err;
        exp_t e;
        memread = 1'b1; memwrite = 1'b0; addr = 32'h300; bif.bus_ack = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        vectors++;
        if (bif.bus_req !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_busy: bus_req=%b, need 1", bif.bus_req);
        end
        memread = 1'b0;
        reset   = 1'b0;
        #1;
        vectors++;
        if (bif.bus_req !== 1'b0 || bus_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_async: bus_req=%b bus_err=%b, need 0 0", bif.bus_req, bus_err);
        end
        #1;
        reset   = 1'b1;
        m_rdata = 32'h0;
        m_err   = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            bif.bus_ack   = 1'b1;
            bif.bus_rdata = 32'hFFFF_FFFF;
            #1;
            vectors++;
            if (bif.bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0 || bus_err !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_late_ack%0d: req=%b stall=%b rdata=%h err=%b, need 0 0 0 0",
                         i, bif.bus_req, stall, rdata, bus_err);
            end
            @(posedge clk);
            #1;
        end
        bif.bus_ack = 1'b0;
        rdat = $urandom;
        e = model(1'b1, 1'b0, 32'h30C, 32'h0, rdat, 2);
        run_access(1'b1, 1'b0, 32'h30C, 32'h0, rdat, 2, 2,
                   n_stall, n_req, n_mis, rd_ret, rd_aft, b_addr, b_wdata, b_we, held, err);
        vectors++;
        if (rd_ret !== e.rd || n_stall !== e.n_stall || err !== e.err) begin
            miscompares++;
            $display("FAIL midrst_recover: rdata=%h stall_cycles=%0d err=%b, need %h %0d %b",
                     rd_ret, n_stall, err, e.rd, e.n_stall, e.err);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_waits();
        test_misalign();
        test_timeout();
        test_both_strobes();
        test_back_to_back();
        test_random();
        test_reset_midway();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
